// File: rtl/led_rate_ctrl.sv
// led_rate_ctrl: 1 ms timebase, debounced hold-to-repeat buttons adjusting the
// step period, a STEP pulse every PERIOD_MS ms and an 8-bit LED counter.

// One debounce / hold-to-repeat FSM per button; state moves only on ms ticks.
module led_rate_btn #(
    parameter int unsigned DEBOUNCE_MS = 5,
    parameter int unsigned REPEAT_MS   = 100
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic ms_tick,
    input  logic btn_n,     // synchronised, active low
    output logic event_o    // one-cycle adjust event, only in a tick cycle
);
    localparam int unsigned CW = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned RW = $clog2(REPEAT_MS + 1);

    typedef enum logic [1:0] {IDLE, DEB_P, HELD, DEB_R} btn_state_e;

    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic [RW-1:0] rpt_inc;

    assign rpt_inc = rpt_q + 1'b1;

    // state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rpt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
        end
    end

    // next state and adjust event; release debounce keeps rpt so a bounce
    // back to HELD resumes the repeat interval rather than restarting it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        event_o = 1'b0;
        if (ms_tick) begin
            case (state_q)
                IDLE: begin
                    if (!btn_n) begin
                        state_d = DEB_P;
                        cnt_d   = CW'(1);
                    end
                end
                DEB_P: begin
                    if (btn_n) begin
                        state_d = IDLE;
                    end else if (cnt_q == CW'(DEBOUNCE_MS)) begin
                        state_d = HELD;
                        event_o = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (btn_n) begin
                        state_d = DEB_R;
                        cnt_d   = CW'(1);
                    end else if (rpt_inc == RW'(REPEAT_MS)) begin
                        event_o = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_inc;
                    end
                end
                DEB_R: begin
                    if (!btn_n) begin
                        state_d = HELD;
                    end else if (cnt_q == CW'(DEBOUNCE_MS)) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// Top level: button pins in, STEP / PERIOD_MS / LED out.
module led_rate_ctrl #(
    parameter int unsigned CLK_PER_MS  = 100000,
    parameter int unsigned PERIOD_DEF  = 100,
    parameter int unsigned PERIOD_STEP = 10,
    parameter int unsigned PERIOD_MIN  = 10,
    parameter int unsigned PERIOD_MAX  = 2000,
    parameter int unsigned DEBOUNCE_MS = 5,
    parameter int unsigned REPEAT_MS   = 100
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SW_UP_N,
    input  logic        SW_DN_N,
    output logic        STEP,
    output logic [15:0] PERIOD_MS,
    output logic [7:0]  LED
);
    localparam int unsigned NUM_BTN = 2;   // [0]=up, [1]=down
    localparam int unsigned PW      = $clog2(CLK_PER_MS);

    logic [NUM_BTN-1:0]      btn_raw_n;
    logic [NUM_BTN-1:0][1:0] sync_q, sync_d;
    logic [NUM_BTN-1:0]      btn_ev;
    logic [PW-1:0]           presc_q, presc_d;
    logic                    ms_tick;
    logic [15:0]             period_q, period_d;
    logic [15:0]             elapsed_q, elapsed_d;
    logic                    step_q, step_d;
    logic [7:0]              led_q, led_d;
    logic [16:0]             up_sum, dn_floor, elapsed_inc;

    assign btn_raw_n = {SW_DN_N, SW_UP_N};
    assign ms_tick   = (presc_q == PW'(CLK_PER_MS - 1));

    // per-button 2-flop synchroniser shift
    always_comb begin
        sync_d = sync_q;
        for (int i = 0; i < NUM_BTN; i++) sync_d[i] = {sync_q[i][0], btn_raw_n[i]};
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        led_rate_btn #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .REPEAT_MS   (REPEAT_MS)
        ) u_btn (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .ms_tick (ms_tick),
            .btn_n   (sync_q[g][1]),
            .event_o (btn_ev[g])
        );
    end

    // prescaler, period adjust, step generator and LED counter
    always_comb begin
        presc_d = ms_tick ? '0 : presc_q + 1'b1;

        // 17-bit sums so neither clamp can be fooled by wrap-around
        up_sum   = {1'b0, period_q} + 17'(PERIOD_STEP);
        dn_floor = 17'(PERIOD_MIN) + 17'(PERIOD_STEP);
        period_d = period_q;
        if (btn_ev[0] && !btn_ev[1])
            period_d = (up_sum > 17'(PERIOD_MAX)) ? 16'(PERIOD_MAX) : up_sum[15:0];
        else if (btn_ev[1] && !btn_ev[0])
            period_d = ({1'b0, period_q} >= dn_floor) ? period_q - 16'(PERIOD_STEP)
                                                      : 16'(PERIOD_MIN);

        // >= (not ==) so a period shrunk below elapsed fires at the next tick
        elapsed_inc = {1'b0, elapsed_q} + 17'd1;
        step_d      = 1'b0;
        elapsed_d   = elapsed_q;
        if (ms_tick) begin
            if (elapsed_inc >= {1'b0, period_q}) begin
                step_d    = 1'b1;
                elapsed_d = '0;
            end else begin
                elapsed_d = elapsed_inc[15:0];
            end
        end

        led_d = step_q ? led_q + 8'd1 : led_q;
    end

    // registers; synchronisers preset to the idle (high) button level
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q    <= '1;
            presc_q   <= '0;
            period_q  <= 16'(PERIOD_DEF);
            elapsed_q <= '0;
            step_q    <= 1'b0;
            led_q     <= '0;
        end else begin
            sync_q    <= sync_d;
            presc_q   <= presc_d;
            period_q  <= period_d;
            elapsed_q <= elapsed_d;
            step_q    <= step_d;
            led_q     <= led_d;
        end
    end

    assign STEP      = step_q;
    assign PERIOD_MS = period_q;
    assign LED       = led_q;
endmodule

// File: tb/tb_led_rate_ctrl.sv
// Directed bench for led_rate_ctrl with a small timebase. Cycle n is sampled
// on the falling edge just before rising edge n; cycle 0 precedes the first
// rising edge with RST_N high.
module tb_led_rate_ctrl;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        SW_UP_N = 1'b1;
    logic        SW_DN_N = 1'b1;
    logic        STEP;
    logic [15:0] PERIOD_MS;
    logic [7:0]  LED;

    int total = 0;
    int bad   = 0;

    led_rate_ctrl #(
        .CLK_PER_MS (4),
        .PERIOD_DEF (3),
        .PERIOD_STEP(2),
        .PERIOD_MIN (1),
        .PERIOD_MAX (7),
        .DEBOUNCE_MS(2),
        .REPEAT_MS  (3)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SW_UP_N  (SW_UP_N),
        .SW_DN_N  (SW_DN_N),
        .STEP     (STEP),
        .PERIOD_MS(PERIOD_MS),
        .LED      (LED)
    );

    always #5 CLK = ~CLK;

    // leaves the bench at the cycle-0 sample point with buttons idle
    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        SW_UP_N = 1'b1;
        SW_DN_N = 1'b1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if (STEP !== 1'b0 || LED !== 8'd0 || PERIOD_MS !== 16'd3) begin
            bad++;
            $display("FAIL reset: step=%b led=%0d period=%0d, want 0 0 3", STEP, LED, PERIOD_MS);
        end
    endtask

    // idle buttons: STEP in cycles 12,24,36 only, LED counts them
    task automatic test_free_run();
        int exp_led;
        do_reset();
        for (int n = 0; n <= 40; n++) begin
            exp_led = (n > 12 ? 1 : 0) + (n > 24 ? 1 : 0) + (n > 36 ? 1 : 0);
            total++;
            if (STEP !== (n == 12 || n == 24 || n == 36)) begin
                bad++;
                $display("FAIL free_run step cyc=%0d: got %b", n, STEP);
            end
            total++;
            if (LED !== 8'(exp_led) || PERIOD_MS !== 16'd3) begin
                bad++;
                $display("FAIL free_run led/period cyc=%0d: got %0d/%0d want %0d/3",
                         n, LED, PERIOD_MS, exp_led);
            end
            @(negedge CLK);
        end
    endtask

    // button low for exactly one tick: no event
    task automatic test_glitch();
        do_reset();
        for (int n = 0; n <= 30; n++) begin
            if (n == 0) SW_UP_N = 1'b0;
            if (n == 4) SW_UP_N = 1'b1;
            total++;
            if (PERIOD_MS !== 16'd3) begin
                bad++;
                $display("FAIL glitch cyc=%0d: period %0d want 3", n, PERIOD_MS);
            end
            @(negedge CLK);
        end
    endtask

    // hold up: 5 at acceptance, 7 after repeat, clamp; release, down, re-press up
    task automatic test_up_hold();
        int exp_p;
        do_reset();
        for (int n = 0; n <= 95; n++) begin
            if (n == 0)  SW_UP_N = 1'b0;
            if (n == 40) SW_UP_N = 1'b1;
            if (n == 56) SW_DN_N = 1'b0;
            if (n == 68) SW_DN_N = 1'b1;
            if (n == 80) SW_UP_N = 1'b0;
            exp_p = (n < 12) ? 3 : (n < 24) ? 5 : (n < 68) ? 7 : (n < 92) ? 5 : 7;
            total++;
            if (PERIOD_MS !== 16'(exp_p)) begin
                bad++;
                $display("FAIL up_hold cyc=%0d: period %0d want %0d", n, PERIOD_MS, exp_p);
            end
            @(negedge CLK);
        end
        SW_UP_N = 1'b1;
    endtask

    // hold down: 3 -> 1 (clamp), STEP then every 4 cycles
    task automatic test_dn_hold();
        do_reset();
        for (int n = 0; n <= 41; n++) begin
            if (n == 0) SW_DN_N = 1'b0;
            total++;
            if (PERIOD_MS !== ((n < 12) ? 16'd3 : 16'd1)) begin
                bad++;
                $display("FAIL dn_hold period cyc=%0d: got %0d", n, PERIOD_MS);
            end
            total++;
            if (STEP !== (n >= 12 && n <= 40 && n % 4 == 0)) begin
                bad++;
                $display("FAIL dn_hold step cyc=%0d: got %b", n, STEP);
            end
            @(negedge CLK);
        end
        total++;
        if (LED !== 8'd8) begin
            bad++;
            $display("FAIL dn_hold led: got %0d want 8", LED);
        end
        SW_DN_N = 1'b1;
    endtask

    // both pressed together: events coincide, period never moves
    task automatic test_both();
        do_reset();
        for (int n = 0; n <= 40; n++) begin
            if (n == 0) begin
                SW_UP_N = 1'b0;
                SW_DN_N = 1'b0;
            end
            total++;
            if (PERIOD_MS !== 16'd3 || STEP !== (n == 12 || n == 24 || n == 36)) begin
                bad++;
                $display("FAIL both cyc=%0d: period %0d step %b", n, PERIOD_MS, STEP);
            end
            @(negedge CLK);
        end
        SW_UP_N = 1'b1;
        SW_DN_N = 1'b1;
    endtask

    // 256 steps wrap LED, then reset mid-period and mid-debounce
    task automatic test_wrap_reset();
        do_reset();
        for (int n = 0; n <= 3093; n++) begin
            if (n == 3085) SW_UP_N = 1'b0;
            if (n == 3061) begin
                total++;
                if (LED !== 8'd255) begin
                    bad++;
                    $display("FAIL wrap led255: got %0d", LED);
                end
            end
            if (n == 3072) begin
                total++;
                if (STEP !== 1'b1 || LED !== 8'd255) begin
                    bad++;
                    $display("FAIL wrap step256: step %b led %0d, want 1 255", STEP, LED);
                end
            end
            if (n == 3073) begin
                total++;
                if (LED !== 8'd0) begin
                    bad++;
                    $display("FAIL wrap led0: got %0d", LED);
                end
            end
            if (n == 3093) begin
                total++;
                if (LED !== 8'd1 || PERIOD_MS !== 16'd3) begin
                    bad++;
                    $display("FAIL pre_reset: led %0d period %0d, want 1 3", LED, PERIOD_MS);
                end
            end
            if (n < 3093) @(negedge CLK);
        end
        RST_N = 1'b0;
        #1;
        total++;
        if (LED !== 8'd0 || STEP !== 1'b0 || PERIOD_MS !== 16'd3) begin
            bad++;
            $display("FAIL async_reset: led %0d step %b period %0d", LED, STEP, PERIOD_MS);
        end
        SW_UP_N = 1'b1;
        do_reset();
        for (int n = 0; n <= 30; n++) begin
            total++;
            if (PERIOD_MS !== 16'd3 || STEP !== (n == 12 || n == 24)) begin
                bad++;
                $display("FAIL post_reset cyc=%0d: period %0d step %b", n, PERIOD_MS, STEP);
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_glitch();
        test_up_hold();
        test_dn_hold();
        test_both();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
